// File: rtl/uart_led_cmd_parser.sv
// rtl/uart_led_cmd_parser.sv - UART colour packet parser driving the WS2812 colour register
//
// Pulls bytes from the UART RX FIFO and parses 5-byte packets {HEADER, G, R, B, CHK}.
// A good packet (CHK == G^R^B) updates o_Colour and is answered with ACK_BYTE. A bad
// checksum or an inter-byte timeout is answered with NAK_BYTE.
//
// Ports:
//   Clock, Reset           system clock (rising edge), asynchronous active-high reset
//   i_Fifo_Ready/Data      RX FIFO not-empty flag and head byte
//   o_Fifo_Read            1-cycle pop strobe, same cycle the byte is sampled
//   i_Tx_Busy              UART transmitter busy
//   o_Tx_Start/o_Tx_Data   1-cycle send strobe and the reply byte
//   o_Colour               {G,R,B} of the last good packet
//   o_Colour_Valid         1-cycle pulse when o_Colour is loaded
//   o_Packet_Count         good packets, wraps
//   o_Error_Count          bad packets, saturates at 255
module uart_led_cmd_parser #(
  parameter int          CLOCK_FREQUENCY = 80000000,
  parameter int          TIMEOUT_US      = 1000,
  parameter logic [7:0]  HEADER          = 8'hA5,
  parameter logic [7:0]  ACK_BYTE        = 8'h06,
  parameter logic [7:0]  NAK_BYTE        = 8'h15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_Fifo_Ready,
  input  logic [7:0]  i_Fifo_Data,
  output logic        o_Fifo_Read,
  input  logic        i_Tx_Busy,
  output logic        o_Tx_Start,
  output logic [7:0]  o_Tx_Data,
  output logic [23:0] o_Colour,
  output logic        o_Colour_Valid,
  output logic [7:0]  o_Packet_Count,
  output logic [7:0]  o_Error_Count
);

  localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, GREEN, RED, BLUE, CHECK, REPLY} state_t;

  state_t          state, state_next;
  logic            gap;          // set for the cycle after a pop so the FIFO flags can settle
  logic [TW-1:0]   timer;
  logic [7:0]      green, red, blue;
  logic [7:0]      reply_byte;
  logic            pop, in_packet, timeout, chk_good;

  always_comb begin
    state_next = state;
    in_packet  = (state == GREEN) || (state == RED) || (state == BLUE) || (state == CHECK);
    pop        = ((state == IDLE) || in_packet) && i_Fifo_Ready && !gap;
    timeout    = in_packet && !pop && (timer == TW'(TIMEOUT_CYCLES - 1));
    chk_good   = (i_Fifo_Data == (green ^ red ^ blue));
    case (state)
      IDLE:    if (pop && i_Fifo_Data == HEADER) state_next = GREEN;
      GREEN:   if (pop) state_next = RED;
      RED:     if (pop) state_next = BLUE;
      BLUE:    if (pop) state_next = CHECK;
      CHECK:   if (pop) state_next = REPLY;
      REPLY:   if (!i_Tx_Busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = REPLY;
  end

  assign o_Fifo_Read = pop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      gap            <= 1'b0;
      timer          <= '0;
      green          <= '0;
      red            <= '0;
      blue           <= '0;
      reply_byte     <= '0;
      o_Tx_Start     <= 1'b0;
      o_Tx_Data      <= '0;
      o_Colour       <= '0;
      o_Colour_Valid <= 1'b0;
      o_Packet_Count <= '0;
      o_Error_Count  <= '0;
    end else begin
      state          <= state_next;
      gap            <= pop;
      o_Colour_Valid <= 1'b0;
      o_Tx_Start     <= 1'b0;

      // Runs only between packet bytes; a pop restarts the gap measurement.
      if (in_packet && !pop) timer <= timer + TW'(1);
      else                   timer <= '0;

      if (pop) begin
        case (state)
          GREEN: green <= i_Fifo_Data;
          RED:   red   <= i_Fifo_Data;
          BLUE:  blue  <= i_Fifo_Data;
          CHECK: begin
            if (chk_good) begin
              o_Colour       <= {green, red, blue};
              o_Colour_Valid <= 1'b1;
              o_Packet_Count <= o_Packet_Count + 8'd1;
              reply_byte     <= ACK_BYTE;
            end else begin
              reply_byte <= NAK_BYTE;
              if (o_Error_Count != 8'hFF) o_Error_Count <= o_Error_Count + 8'd1;
            end
          end
          default: ;
        endcase
      end

      if (timeout) begin
        green      <= '0;
        red        <= '0;
        blue       <= '0;
        reply_byte <= NAK_BYTE;
        if (o_Error_Count != 8'hFF) o_Error_Count <= o_Error_Count + 8'd1;
      end

      // Registered strobe: fires one cycle after the colour pulse, so the two never overlap.
      if (state == REPLY && !i_Tx_Busy) begin
        o_Tx_Start <= 1'b1;
        o_Tx_Data  <= reply_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// tb/tb_uart_led_cmd_parser.sv - directed self-checking bench for uart_led_cmd_parser
module tb_uart_led_cmd_parser;

  localparam int CLK_HZ   = 1000000;
  localparam int TOUT_US  = 40;      // 40-cycle inter-byte timeout

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        i_Fifo_Ready = 1'b0;
  logic [7:0]  i_Fifo_Data = 8'h00;
  logic        o_Fifo_Read;
  logic        i_Tx_Busy = 1'b0;
  logic        o_Tx_Start;
  logic [7:0]  o_Tx_Data;
  logic [23:0] o_Colour;
  logic        o_Colour_Valid;
  logic [7:0]  o_Packet_Count;
  logic [7:0]  o_Error_Count;

  int tests = 0;
  int fails = 0;

  int         cv_cnt = 0;
  int         tx_cnt = 0;
  int         rd_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] last_tx = 8'h00;

  uart_led_cmd_parser #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .TIMEOUT_US     (TOUT_US)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .i_Fifo_Ready  (i_Fifo_Ready),
    .i_Fifo_Data   (i_Fifo_Data),
    .o_Fifo_Read   (o_Fifo_Read),
    .i_Tx_Busy     (i_Tx_Busy),
    .o_Tx_Start    (o_Tx_Start),
    .o_Tx_Data     (o_Tx_Data),
    .o_Colour      (o_Colour),
    .o_Colour_Valid(o_Colour_Valid),
    .o_Packet_Count(o_Packet_Count),
    .o_Error_Count (o_Error_Count)
  );

  always #5 Clock = ~Clock;

  // Samples mid-cycle, once per clock period.
  always @(posedge Clock) begin
    #3;
    if (o_Colour_Valid) cv_cnt++;
    if (o_Tx_Start) begin
      tx_cnt++;
      last_tx = o_Tx_Data;
    end
    if (o_Fifo_Read) rd_cnt++;
    if (o_Colour_Valid && o_Tx_Start) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Offer one byte at a negedge and hold it until the DUT pops it.
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    i_Fifo_Ready = 1'b1;
    i_Fifo_Data  = b;
    for (int k = 0; k < 12 && !done; k++) begin
      #1;
      if (o_Fifo_Read) done = 1;
      @(negedge Clock);
    end
    i_Fifo_Ready = 1'b0;
    if (!done) check("send_byte_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_packet(input logic [7:0] g, input logic [7:0] r,
                             input logic [7:0] b, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(g);
    send_byte(r);
    send_byte(b);
    send_byte(c);
  endtask

  initial begin
    wait_cycles(3);
    check("reset_colour",  32'(o_Colour), 32'h0);
    check("reset_cvalid",  32'(o_Colour_Valid), 32'h0);
    check("reset_txstart", 32'(o_Tx_Start), 32'h0);
    check("reset_txdata",  32'(o_Tx_Data), 32'h0);
    check("reset_pkt",     32'(o_Packet_Count), 32'h0);
    check("reset_err",     32'(o_Error_Count), 32'h0);
    check("reset_read",    32'(o_Fifo_Read), 32'h0);
    Reset = 1'b0;
    wait_cycles(2);

    // 1: good packet
    send_packet(8'h10, 8'h20, 8'h30, 8'h00);
    wait_cycles(4);
    check("t1_colour", 32'(o_Colour), 32'h102030);
    check("t1_cv_cnt", 32'(cv_cnt), 32'd1);
    check("t1_tx_cnt", 32'(tx_cnt), 32'd1);
    check("t1_tx",     32'(last_tx), 32'h06);
    check("t1_pkt",    32'(o_Packet_Count), 32'd1);
    check("t1_err",    32'(o_Error_Count), 32'd0);

    // 2: bad checksum
    send_packet(8'h10, 8'h20, 8'h30, 8'hFF);
    wait_cycles(4);
    check("t2_colour", 32'(o_Colour), 32'h102030);
    check("t2_cv_cnt", 32'(cv_cnt), 32'd1);
    check("t2_tx_cnt", 32'(tx_cnt), 32'd2);
    check("t2_tx",     32'(last_tx), 32'h15);
    check("t2_err",    32'(o_Error_Count), 32'd1);
    check("t2_pkt",    32'(o_Packet_Count), 32'd1);

    // 3: leading junk discarded without reply
    send_byte(8'h00);
    send_byte(8'h7E);
    wait_cycles(4);
    check("t3_junk_tx_cnt", 32'(tx_cnt), 32'd2);
    send_packet(8'h01, 8'h02, 8'h03, 8'h00);
    wait_cycles(4);
    check("t3_colour", 32'(o_Colour), 32'h010203);
    check("t3_tx",     32'(last_tx), 32'h06);
    check("t3_tx_cnt", 32'(tx_cnt), 32'd3);
    check("t3_pkt",    32'(o_Packet_Count), 32'd2);
    check("t3_err",    32'(o_Error_Count), 32'd1);

    // 4: timeout mid-packet, then recovery
    send_byte(8'hA5);
    send_byte(8'h11);
    wait_cycles(100);
    check("t4_to_tx_cnt", 32'(tx_cnt), 32'd4);
    check("t4_to_tx",     32'(last_tx), 32'h15);
    check("t4_to_err",    32'(o_Error_Count), 32'd2);
    check("t4_to_colour", 32'(o_Colour), 32'h010203);
    send_packet(8'h11, 8'h22, 8'h33, 8'h00);
    wait_cycles(4);
    check("t4_colour", 32'(o_Colour), 32'h112233);
    check("t4_tx",     32'(last_tx), 32'h06);
    check("t4_pkt",    32'(o_Packet_Count), 32'd3);

    // 5: transmitter busy holds the reply and blocks pops
    i_Tx_Busy = 1'b1;
    send_packet(8'h01, 8'h01, 8'h01, 8'h01);
    i_Fifo_Ready = 1'b1;
    i_Fifo_Data  = 8'h00;
    rd_cnt = 0;
    wait_cycles(500);
    check("t5_busy_tx_cnt", 32'(tx_cnt), 32'd5);
    check("t5_busy_reads",  32'(rd_cnt), 32'd0);
    check("t5_colour",      32'(o_Colour), 32'h010101);
    i_Fifo_Ready = 1'b0;
    i_Tx_Busy    = 1'b0;
    wait_cycles(3);
    check("t5_tx_cnt", 32'(tx_cnt), 32'd6);
    check("t5_tx",     32'(last_tx), 32'h06);
    check("t5_pkt",    32'(o_Packet_Count), 32'd4);

    // 6: reset mid-packet
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h20);
    Reset = 1'b1;
    wait_cycles(2);
    check("t6_colour", 32'(o_Colour), 32'h0);
    check("t6_pkt",    32'(o_Packet_Count), 32'h0);
    check("t6_err",    32'(o_Error_Count), 32'h0);
    check("t6_txdata", 32'(o_Tx_Data), 32'h0);
    Reset = 1'b0;
    wait_cycles(2);
    check("t6_no_reply", 32'(tx_cnt), 32'd6);
    send_packet(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    wait_cycles(4);
    check("t6_colour_after", 32'(o_Colour), 32'h0A0B0C);
    check("t6_pkt_after",    32'(o_Packet_Count), 32'd1);
    check("t6_tx",           32'(last_tx), 32'h06);

    // Packet counter wrap: 255 more good packets -> 256 total
    for (int i = 0; i < 255; i++) send_packet(8'h01, 8'h02, 8'h04, 8'h07);
    wait_cycles(4);
    check("wrap_pkt", 32'(o_Packet_Count), 32'd0);
    check("wrap_colour", 32'(o_Colour), 32'h010204);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_packet(8'h01, 8'h02, 8'h04, 8'h00);
    wait_cycles(4);
    check("sat_err", 32'(o_Error_Count), 32'd255);
    check("sat_tx",  32'(last_tx), 32'h15);
    check("overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
